mem_copy_master: RTL

Memory-side initiator that drives one port of the team's 32-bit word RAM request/response interface (req/we/be/addr/wdata out; rvalid/rdata back). It executes software-configured block operations: word copy from a source region to a destination region, or fill of a region with a constant. It sits between a control register block and port B of the dual-port RAM. It honours the responder's read latency by waiting for rvalid, and never leaves a read outstanding.

---
 rtl/mem_copy_master.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_copy_master.sv
// Block copy / fill initiator for one port of the 32-bit word RAM request/response bus.
// At most one read is ever in flight; m_* outputs come from registers or decoded state only.
module mem_copy_master #(
  parameter int LenW = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            start_i,
  input  logic            mode_i,
  input  logic [31:0]     src_addr_i,
  input  logic [31:0]     dst_addr_i,
  input  logic [LenW-1:0] len_i,
  input  logic [31:0]     fill_data_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            aborted_o,
  output logic [LenW-1:0] count_o,
  output logic            m_req_o,
  output logic            m_we_o,
  output logic [3:0]      m_be_o,
  output logic [31:0]     m_addr_o,
  output logic [31:0]     m_wdata_o,
  input  logic            m_rvalid_i,
  input  logic [31:0]     m_rdata_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [31:0]     fill_q, fill_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [LenW-1:0] rem_q, rem_d;
  logic [LenW-1:0] count_q, count_d;
  logic            mode_q, mode_d;
  logic            err_q, err_d;
  logic            abrt_q, abrt_d;
  logic            abpend_q, abpend_d;
  logic            misaligned;

  assign misaligned = (!mode_i && (src_addr_i[1:0] != 2'b00)) || (dst_addr_i[1:0] != 2'b00);

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    fill_d   = fill_q;
    rem_d    = rem_q;
    count_d  = count_q;
    mode_d   = mode_q;
    err_d    = err_q;
    abrt_d   = abrt_q;
    abpend_d = abpend_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d    = src_addr_i;
          dst_d    = dst_addr_i;
          fill_d   = fill_data_i;
          rem_d    = len_i;
          mode_d   = mode_i;
          count_d  = '0;
          err_d    = 1'b0;
          abrt_d   = 1'b0;
          abpend_d = 1'b0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (len_i == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = mode_i ? S_WRITE : S_READ;
          end
        end
      end
      S_READ: begin
        // An abort here still lets the read issue; WAIT drains it so nothing is left outstanding.
        state_d = S_WAIT;
        if (abort_i) abpend_d = 1'b1;
      end
      S_WAIT: begin
        if (abort_i) abpend_d = 1'b1;
        if (m_rvalid_i) begin
          if (abort_i || abpend_q) begin
            abrt_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        count_d = count_q + LenW'(1);
        src_d   = src_q + 32'd4;
        dst_d   = dst_q + 32'd4;
        rem_d   = rem_q - LenW'(1);
        if (abort_i) begin
          abrt_d  = 1'b1;
          state_d = S_DONE;
        end else if (rem_q == LenW'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = mode_q ? S_WRITE : S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Address / data for the next request are registered; they hold otherwise.
    if (state_d == S_READ) begin
      addr_d = src_d;
    end else if (state_d == S_WRITE) begin
      addr_d  = dst_d;
      wdata_d = mode_d ? fill_d : m_rdata_i;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      fill_q   <= '0;
      rem_q    <= '0;
      count_q  <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      abrt_q   <= 1'b0;
      abpend_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      fill_q   <= fill_d;
      rem_q    <= rem_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      abrt_q   <= abrt_d;
      abpend_q <= abpend_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign m_req_o   = (state_q == S_READ) || (state_q == S_WRITE);
  assign m_we_o    = (state_q == S_WRITE);
  assign m_be_o    = (state_q == S_WRITE) ? 4'hF : 4'h0;
  assign m_addr_o  = addr_q;
  assign m_wdata_o = wdata_q;
  assign busy_o    = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_WRITE);
  assign done_o    = (state_q == S_DONE);
  assign err_o     = err_q;
  assign aborted_o = abrt_q;
  assign count_o   = count_q;

endmodule
